serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised WIDTH-bit adder/subtractor. Uses one single-bit full adder/subtractor cell,
//  time-multiplexed LSB-first, one bit per clock.
//  Trades latency (WIDTH cycles) for area, with a start/busy/done handshake.
//  Sits beside the combinational fas cell in the arithmetic datapath.
//  Adds carry/borrow-in chaining and a signed-overflow flag.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 1
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled on rising clk while idle
//  a         in   WIDTH  operand A (unsigned / two's complement)
//  b         in   WIDTH  operand B
//  cin       in   1      carry-in (add) / borrow-in (sub)
//  add_nsub  in   1      1 = A+B+cin ; 0 = A-B-cin
//  busy      out  1      high while an operation is in flight
//  done      out  1      one-cycle pulse: result/cout/ovf just updated
//  result    out  WIDTH  sum/difference mod 2^WIDTH
//  cout      out  1      carry-out (add) / borrow-out (sub)
//  ovf       out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; busy, done, result, cout, ovf = 0; internal regs cleared.
//  - IDLE + start=1 at edge k: latch a, b, cin, add_nsub into shift regs; bit counter = 0.
//    State -> RUN; busy=1 from edge k.
//  - RUN: each edge processes bit i (i=0..WIDTH-1) through the fas cell.
//    Cell mode pin is driven so the cell adds when latched add_nsub=1 and subtracts when 0.
//    Carry/borrow reg feeds the next bit; the result bit shifts into the MSB of the result shift reg.
//  - On the edge processing bit WIDTH-1 (edge k+WIDTH):
//    result, cout and ovf regs load; done=1 for exactly one cycle; busy=0; state -> IDLE.
//    Latency: start edge to done = WIDTH edges.
//  - ovf = carry into MSB XOR carry out of MSB (add); same rule on borrow chain for sub.
//    Equivalently: sign(a) != sign(b_eff) fails to match sign(result) per two's-complement rules.
//  - result/cout/ovf hold their last completed value until the next done. Never partial values.
//  - start while busy: ignored; no queuing; operands unchanged.
//  - start in the done cycle (state IDLE): accepted; next done WIDTH edges later.
//  - Inputs a/b/cin/add_nsub may change freely after the start edge; only latched copies are used.
//  - Reset mid-RUN: immediate abort, all outputs 0, no done after reset release.
//  - WIDTH=1: RUN lasts one edge; done follows the start edge directly.
// STRUCTURE
//  - Package addsub_pkg:
//      typedef enum logic {S_IDLE, S_RUN} addsub_state_t
//      localparam MODE_ADD=1'b1, MODE_SUB=1'b0
//  - Bit-counter width is $clog2(WIDTH) (min 1), local to the module.
//  - One sub-module: the existing single-bit fas cell, instantiated once.
//    Everything else (FSM, shift regs, carry reg, counter, output regs) is inline.
// TESTING  (WIDTH=8)
//  - add 100+27, cin=0 -> done exactly 8 edges after start; result=127, cout=0, ovf=0.
//  - add 200+100 -> result=44, cout=1, ovf=0.
//    add 100+50 -> result=150, cout=0, ovf=1.
//    add 0xFF+0x00, cin=1 -> result=0x00, cout=1.
//  - sub 5-7, cin=0 -> result=0xFE, cout=1, ovf=0.
//    sub 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
//    sub 9-3, cin=1 -> result=5.
//  - start during busy at edge k+3 with new operands:
//    exactly one done at k+8, carrying the first operation's result; busy never drops early.
//  - rst_n=0 at edge k+4 of an operation:
//    busy/done/result/cout/ovf = 0 immediately (async); no done within 16 cycles of release.
//  - start asserted in the done cycle -> accepted; second done 8 edges later with the correct result.
//    Randomised 1000-op sweep vs. reference model (a +/- b +/- cin) passes.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic {S_IDLE, S_RUN} addsub_state_t;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas.sv
// Single-bit full adder/subtractor cell: s = a +/- b +/- cin, with carry or borrow out.
module fas
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    // Sum and difference share the XOR; only the carry/borrow term depends on mode.
    always_comb begin
        s = a ^ b ^ cin;
        if (mode == MODE_SUB) begin
            cout = (~a & b) | (~(a ^ b) & cin);
        end else begin
            cout = (a & b) | ((a ^ b) & cin);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one fas cell, one bit per clock, LSB first.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             add_nsub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    addsub_state_t    state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic             carry, mode_q;
    logic [CW-1:0]    cnt;
    logic             load, step, last;
    logic             cell_s, cell_c;

    fas u_fas (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .mode (mode_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign busy = (state == S_RUN);
    assign last = (cnt == LAST);

    // Result shift register with the new bit entering at the MSB (works for WIDTH=1 too).
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = cell_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Operand capture, per-bit shifting and final result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            mode_q <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= step & last;
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                carry  <= cin;
                mode_q <= add_nsub;
                cnt    <= '0;
                res_sr <= '0;
            end else if (step) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_next;
                carry  <= cell_c;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    result <= res_next;
                    cout   <= cell_c;
                    // carry holds the carry/borrow into the MSB at this point
                    ovf    <= carry ^ cell_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub;
    import addsub_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin, add_nsub;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout, ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_r;
    logic         exp_c, exp_v;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .add_nsub (add_nsub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic m, output logic [W-1:0] r, output logic co,
                         output logic ov);
        int full, sfull, sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m == MODE_ADD) begin
            full  = int'(x) + int'(y) + int'(c);
            sfull = sx + sy + int'(c);
            co    = (full > 255);
        end else begin
            full  = int'(x) - int'(y) - int'(c);
            sfull = sx - sy - int'(c);
            co    = (full < 0);
        end
        r  = full[W-1:0];
        ov = (sfull > 127) || (sfull < -128);
    endtask

    // Called #1 after an edge: present an operation so the next edge starts it.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic m);
        a = x; b = y; cin = c; add_nsub = m;
        start = 1'b1;
        model(x, y, c, m, exp_r, exp_c, exp_v);
    endtask

    // Consume the start edge, scramble inputs, wait for done and check the result.
    task automatic finish_op(input string tag);
        int cyc;
        bit got;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); add_nsub = 1'($urandom);
        chk({tag, "_busy_start"}, busy, 1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1;
            else chk({tag, "_busy_run"}, busy, 1);
        end
        chk({tag, "_latency"}, cyc, W);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_cout"}, cout, exp_c);
        chk({tag, "_ovf"}, ovf, exp_v);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int ndone, first_done;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; add_nsub = 1'b1;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        issue(8'd100, 8'd27, 1'b0, MODE_ADD);  finish_op("add_100_27");
        chk("add_100_27_const", result, 127);
        @(posedge clk); #1;
        issue(8'd200, 8'd100, 1'b0, MODE_ADD); finish_op("add_200_100");
        @(posedge clk); #1;
        issue(8'd100, 8'd50, 1'b0, MODE_ADD);  finish_op("add_100_50");
        @(posedge clk); #1;
        issue(8'hFF, 8'h00, 1'b1, MODE_ADD);   finish_op("add_ff_cin");
        @(posedge clk); #1;
        issue(8'd5, 8'd7, 1'b0, MODE_SUB);     finish_op("sub_5_7");
        chk("sub_5_7_const", result, 8'hFE);
        @(posedge clk); #1;
        issue(8'h80, 8'h01, 1'b0, MODE_SUB);   finish_op("sub_80_01");
        @(posedge clk); #1;
        issue(8'd9, 8'd3, 1'b1, MODE_SUB);     finish_op("sub_9_3_bin");

        // Start while busy is ignored: one done at k+8 with the first result.
        @(posedge clk); #1;
        issue(8'd100, 8'd27, 1'b0, MODE_ADD);
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                a = 8'd1; b = 8'd1; cin = 1'b0; add_nsub = MODE_SUB; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("overlap_busy", busy, (cyc < 8) ? 1 : 0);
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
                chk("overlap_result", result, 127);
            end
        end
        chk("overlap_ndone", ndone, 1);
        chk("overlap_when", first_done, 8);

        // Asynchronous reset in the middle of an operation.
        issue(8'd200, 8'd100, 1'b0, MODE_ADD);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_ovf", ovf, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("midrst_quiet", ndone, 0);

        // Start in the done cycle, back to back.
        issue(8'd5, 8'd7, 1'b0, MODE_SUB);     finish_op("chain_first");
        chk("chain_done_cycle", done, 1);
        issue(8'd100, 8'd50, 1'b0, MODE_ADD);  finish_op("chain_second");

        // Random sweep, mixing done-cycle starts with idle gaps.
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            finish_op("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
